// File: rtl/plic_regfile.sv
// PLIC register file: priority/pending/enable/threshold/claim-complete map behind a
// one-cycle valid/ready register bus, plus the bus request/response types it uses.
package reg_intf;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_intf_req_a32_d32;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_intf_resp_d32;
endpackage

module plic_regfile #(
  parameter int unsigned   NumSource = 63,
  parameter int unsigned   NumTarget = 2,
  parameter int unsigned   MaxPrio   = 7,
  parameter logic [31:0]   BaseAddr  = 32'h0C00_0000,
  localparam int unsigned  PrioW     = $clog2(MaxPrio + 1),
  localparam int unsigned  IdW       = $clog2(NumSource + 1),
  localparam int unsigned  NumWords  = NumSource / 32 + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  reg_intf::reg_intf_req_a32_d32        req_i,
  output reg_intf::reg_intf_resp_d32           resp_o,
  input  logic [NumSource:0]                   ip_i,
  input  logic [NumTarget-1:0][IdW-1:0]        cc_i,
  output logic [NumSource:0][PrioW-1:0]        prio_o,
  output logic [NumTarget-1:0][NumSource:0]    ie_o,
  output logic [NumTarget-1:0][PrioW-1:0]      threshold_o,
  output logic [NumTarget-1:0]                 claim_o,
  output logic [NumTarget-1:0][IdW-1:0]        claim_id_o,
  output logic [NumTarget-1:0]                 complete_o,
  output logic [NumTarget-1:0][IdW-1:0]        complete_id_o
);

  localparam int unsigned TgtW = (NumTarget > 1) ? $clog2(NumTarget) : 1;

  typedef enum logic {S_IDLE, S_RESP} state_e;
  typedef enum logic [2:0] {K_NONE, K_PRIO, K_PEND, K_IE, K_THR, K_CC} kind_e;

  state_e                              state_q;
  logic                                ready_q, err_q;
  logic [31:0]                         rdata_q;
  logic [NumSource:0][PrioW-1:0]       prio_q;
  logic [NumTarget-1:0][NumSource:0]   ie_q;
  logic [NumTarget-1:0][PrioW-1:0]     thr_q;
  logic [NumTarget-1:0]                claim_q, complete_q;
  logic [NumTarget-1:0][IdW-1:0]       claim_id_q, complete_id_q;

  kind_e              kind_c;
  logic [31:0]        off_c, rel_c, rdata_c;
  logic [IdW-1:0]     src_c;
  logic [TgtW-1:0]    tgt_c;
  int unsigned        word_c, bi;
  logic [NumSource:0] ie_mask_c, ie_val_c;
  logic               err_c;

  function automatic logic [PrioW-1:0] sat(input logic [31:0] v);
    return (v > MaxPrio) ? PrioW'(MaxPrio) : v[PrioW-1:0];
  endfunction

  always_comb begin
    off_c     = req_i.addr - BaseAddr;
    rel_c     = '0;
    kind_c    = K_NONE;
    src_c     = '0;
    tgt_c     = '0;
    word_c    = 0;
    bi        = 0;
    rdata_c   = '0;
    ie_mask_c = '0;
    ie_val_c  = '0;
    // Addresses below the base wrap to a huge offset and fall through to unmapped.
    if (off_c < 32'h1000) begin
      if ((off_c >> 2) <= NumSource) kind_c = K_PRIO;
      src_c = IdW'(off_c >> 2);
    end else if (off_c < 32'h2000) begin
      rel_c  = off_c - 32'h1000;
      word_c = rel_c >> 2;
      if (word_c < NumWords) kind_c = K_PEND;
    end else if (off_c < 32'h2000 + 32'h80 * NumTarget) begin
      rel_c  = off_c - 32'h2000;
      tgt_c  = TgtW'(rel_c >> 7);
      word_c = (rel_c >> 2) & 32'h1F;
      if (word_c < NumWords) kind_c = K_IE;
    end else if (off_c >= 32'h20_0000 && off_c < 32'h20_0000 + 32'h1000 * NumTarget) begin
      rel_c = off_c - 32'h20_0000;
      tgt_c = TgtW'(rel_c >> 12);
      if (rel_c[11:2] == 10'd0)      kind_c = K_THR;
      else if (rel_c[11:2] == 10'd1) kind_c = K_CC;
    end

    case (kind_c)
      K_PRIO: rdata_c = 32'(prio_q[src_c]);
      K_PEND, K_IE: begin
        for (int unsigned b = 0; b < 32; b++) begin
          bi = word_c * 32 + b;
          if (bi >= 1 && bi <= NumSource) begin
            rdata_c[b] = (kind_c == K_PEND) ? ip_i[IdW'(bi)] : ie_q[tgt_c][IdW'(bi)];
            ie_mask_c[IdW'(bi)] = req_i.wstrb[b[4:3]];
            ie_val_c[IdW'(bi)]  = req_i.wdata[b];
          end
        end
      end
      K_THR:   rdata_c = 32'(thr_q[tgt_c]);
      K_CC:    rdata_c = 32'(cc_i[tgt_c]);
      default: rdata_c = '0;
    endcase

    err_c = (kind_c == K_NONE) || (kind_c == K_PEND && req_i.write);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      prio_q        <= '0;
      ie_q          <= '0;
      thr_q         <= '0;
      claim_q       <= '0;
      complete_q    <= '0;
      claim_id_q    <= '0;
      complete_id_q <= '0;
    end else begin
      claim_q    <= '0;
      complete_q <= '0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
          if (req_i.valid) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            rdata_q <= req_i.write ? '0 : rdata_c;
            err_q   <= err_c;
            case (kind_c)
              K_PRIO: if (req_i.write && req_i.wstrb[0] && src_c != '0)
                        prio_q[src_c] <= sat(req_i.wdata);
              K_IE:   if (req_i.write)
                        ie_q[tgt_c] <= (ie_q[tgt_c] & ~ie_mask_c) | (ie_val_c & ie_mask_c);
              K_THR:  if (req_i.write && req_i.wstrb[0])
                        thr_q[tgt_c] <= sat(req_i.wdata);
              K_CC: begin
                if (!req_i.write) begin
                  claim_q[tgt_c]    <= 1'b1;
                  claim_id_q[tgt_c] <= cc_i[tgt_c];
                end else if (req_i.wdata >= 32'd1 && req_i.wdata <= NumSource) begin
                  complete_q[tgt_c]    <= 1'b1;
                  complete_id_q[tgt_c] <= req_i.wdata[IdW-1:0];
                end
              end
              default: ;
            endcase
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign resp_o      = '{ready: ready_q, rdata: rdata_q, error: err_q};
  assign prio_o      = prio_q;
  assign ie_o        = ie_q;
  assign threshold_o = thr_q;
  // Pulses are launched on acceptance, so reset during the response cycle must mask them.
  assign claim_o       = claim_q & {NumTarget{rst_ni}};
  assign complete_o    = complete_q & {NumTarget{rst_ni}};
  assign claim_id_o    = claim_id_q;
  assign complete_id_o = complete_id_q;

endmodule

// File: tb/tb_plic_regfile.sv
// Scoreboarded directed bench for plic_regfile with default parameters.
module tb_plic_regfile;
  localparam logic [31:0] B = 32'h0C00_0000;

  logic clk = 1'b0;
  logic rst_ni;
  reg_intf::reg_intf_req_a32_d32 req;
  reg_intf::reg_intf_resp_d32    resp;
  logic [63:0]       ip;
  logic [1:0][5:0]   cc;
  logic [63:0][2:0]  prio;
  logic [1:0][63:0]  ie;
  logic [1:0][2:0]   thr;
  logic [1:0]        claim, complete;
  logic [1:0][5:0]   claim_id, complete_id;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  string       name_q[$];
  int          claim0_cnt = 0, claim1_cnt = 0, comp0_cnt = 0, comp1_cnt = 0;
  logic [5:0]  claim0_id = '0, claim1_id = '1, comp1_id = '0;

  plic_regfile dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .resp_o(resp), .ip_i(ip), .cc_i(cc),
    .prio_o(prio), .ie_o(ie), .threshold_o(thr), .claim_o(claim), .claim_id_o(claim_id),
    .complete_o(complete), .complete_id_o(complete_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (claim[0])    begin claim0_cnt++; claim0_id = claim_id[0]; end
    if (claim[1])    begin claim1_cnt++; claim1_id = claim_id[1]; end
    if (complete[0]) comp0_cnt++;
    if (complete[1]) begin comp1_cnt++; comp1_id = complete_id[1]; end
  end

  always @(negedge clk) begin
    if (resp.ready) begin
      logic [32:0] e;
      string n;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got rdata=%h err=%0b", resp.rdata, resp.error);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if ({resp.rdata, resp.error} !== e) begin
          errors++;
          $display("FAIL %s got rdata=%h err=%0b exp rdata=%h err=%0b",
                   n, resp.rdata, resp.error, e[32:1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic xact(input string n, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] er, input logic ee);
    @(posedge clk); #1;
    req.addr = a; req.write = w; req.wdata = d; req.wstrb = s; req.valid = 1'b1;
    exp_q.push_back({er, ee});
    name_q.push_back(n);
    @(posedge clk); #1;
    chk({n, "_lat"}, 64'(resp.ready), 64'd1);
    // valid stays high across the RESP->IDLE edge: must not start a second access
    @(posedge clk); #1;
    chk({n, "_one"}, 64'(resp.ready), 64'd0);
    req.valid = 1'b0;
  endtask

  initial begin
    int c0, c1, k1, k0;
    rst_ni = 1'b0; req = '0; ip = '0; cc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(resp.ready), 64'd0);
    chk("rst_rdata", 64'(resp.rdata), 64'd0);
    chk("rst_prio_lo", prio[21:0], 64'd0);
    chk("rst_ie1", ie[1], 64'd0);
    chk("rst_thr", 64'(thr), 64'd0);
    chk("rst_pulses", 64'({claim, complete}), 64'd0);
    rst_ni = 1'b1;

    xact("prio2_wr", B + 32'h8, 1'b1, 32'h9, 4'hF, 32'h0, 1'b0);
    chk("prio2_sat", 64'(prio[2]), 64'd7);
    xact("prio2_rd", B + 32'h8, 1'b0, 32'h0, 4'hF, 32'h7, 1'b0);
    xact("prio0_wr", B, 1'b1, 32'h5, 4'hF, 32'h0, 1'b0);
    xact("prio0_rd", B, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
    chk("prio0_stays", 64'(prio[0]), 64'd0);

    xact("ie11_wr", B + 32'h2084, 1'b1, 32'hFFFF_FFFF, 4'b0011, 32'h0, 1'b0);
    chk("ie11_lo", 64'(ie[1][47:32]), 64'hFFFF);
    chk("ie11_hi", 64'(ie[1][63:48]), 64'h0);
    xact("ie11_rd", B + 32'h2084, 1'b0, 32'h0, 4'hF, 32'h0000_FFFF, 1'b0);
    xact("ie10_wr", B + 32'h2080, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
    xact("ie10_rd", B + 32'h2080, 1'b0, 32'h0, 4'hF, 32'hFFFF_FFFE, 1'b0);
    chk("ie0_untouched", ie[0], 64'd0);

    xact("thr0_wr", B + 32'h20_0000, 1'b1, 32'hA, 4'h1, 32'h0, 1'b0);
    chk("thr0_sat", 64'(thr[0]), 64'd7);
    xact("thr0_rd", B + 32'h20_0000, 1'b0, 32'h0, 4'hF, 32'h7, 1'b0);
    xact("thr1_nostrb", B + 32'h20_1000, 1'b1, 32'h3, 4'h0, 32'h0, 1'b0);
    chk("thr1_kept", 64'(thr[1]), 64'd0);

    cc[0] = 6'd5; cc[1] = 6'd0;
    c0 = claim0_cnt; c1 = claim1_cnt;
    xact("claim0_rd", B + 32'h20_0004, 1'b0, 32'h0, 4'hF, 32'h5, 1'b0);
    repeat (2) @(posedge clk);
    chk("claim0_count", 64'(claim0_cnt - c0), 64'd1);
    chk("claim0_id", 64'(claim0_id), 64'd5);
    xact("claim1_rd", B + 32'h20_1004, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
    chk("claim1_count", 64'(claim1_cnt - c1), 64'd1);
    chk("claim1_id", 64'(claim1_id), 64'd0);

    k0 = comp0_cnt; k1 = comp1_cnt;
    xact("comp_5",  B + 32'h20_1004, 1'b1, 32'd5,  4'hF, 32'h0, 1'b0);
    xact("comp_0",  B + 32'h20_1004, 1'b1, 32'd0,  4'hF, 32'h0, 1'b0);
    xact("comp_64", B + 32'h20_1004, 1'b1, 32'd64, 4'hF, 32'h0, 1'b0);
    chk("comp1_count", 64'(comp1_cnt - k1), 64'd1);
    chk("comp1_id", 64'(comp1_id), 64'd5);
    chk("comp0_count", 64'(comp0_cnt - k0), 64'd0);

    xact("pend_wr", B + 32'h1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    xact("unmapped_rd", B + 32'h0400_0000, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
    chk("unmapped_prio2", 64'(prio[2]), 64'd7);
    chk("unmapped_ie1", ie[1], 64'h0000_FFFF_FFFF_FFFE);
    ip = 64'h0000_0002_0000_0003;
    xact("pend1_rd", B + 32'h1004, 1'b0, 32'h0, 4'hF, 32'h2, 1'b0);
    xact("pend0_rd", B + 32'h1000, 1'b0, 32'h0, 4'hF, 32'h2, 1'b0);

    // reset lands in the RESP cycle of a claim read
    c0 = claim0_cnt;
    @(posedge clk); #1;
    req.addr = B + 32'h20_0004; req.write = 1'b0; req.wstrb = 4'hF; req.valid = 1'b1;
    exp_q.push_back({32'h5, 1'b0});
    name_q.push_back("rst_claim_resp");
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(negedge clk);
    chk("rst_claim_nopulse", 64'(claim), 64'd0);
    @(posedge clk); #1;
    req.valid = 1'b0;
    chk("rstr_ready", 64'(resp.ready), 64'd0);
    chk("rstr_rdata", 64'({resp.rdata, resp.error}), 64'd0);
    chk("rstr_prio", 64'(prio[2]), 64'd0);
    chk("rstr_ie", ie[1], 64'd0);
    chk("rstr_thr", 64'(thr), 64'd0);
    chk("rstr_pulses", 64'({claim, complete}), 64'd0);
    chk("rstr_claim_count", 64'(claim0_cnt - c0), 64'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/plic_regfile.md
PLIC_REGFILE -- requirements
Module: plic_regfile

Interface
REQ-001 SHALL have parameter NumSource, default 63, meaning the number of interrupt sources (1..1023); source 0 is reserved.
REQ-002 SHALL have parameter NumTarget, default 2, meaning the number of targets/contexts (1..15872).
REQ-003 SHALL have parameter MaxPrio, default 7, meaning the highest priority value; PrioW = $clog2(MaxPrio+1).
REQ-004 SHALL have parameter BaseAddr, default 32'h0C00_0000, meaning the base of the register map; IdW = $clog2(NumSource+1), NumWords = NumSource/32+1.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port req_i, input, reg_intf::reg_intf_req_a32_d32: bus request (addr, write, wdata, wstrb, valid).
REQ-008 SHALL have port resp_o, output, reg_intf::reg_intf_resp_d32: bus response (ready, rdata, error).
REQ-009 SHALL have port ip_i, input, [NumSource:0]: pending bits from the gateways.
REQ-010 SHALL have port cc_i, input, [NumTarget-1:0][IdW-1:0]: the current best claimable ID per target.
REQ-011 SHALL have port prio_o, output, [NumSource:0][PrioW-1:0]: stored priorities.
REQ-012 SHALL have port ie_o, output, [NumTarget-1:0][NumSource:0]: stored enables.
REQ-013 SHALL have port threshold_o, output, [NumTarget-1:0][PrioW-1:0]: stored thresholds.
REQ-014 SHALL have ports claim_o [NumTarget-1:0] and claim_id_o [NumTarget-1:0][IdW-1:0] (output): one-cycle claim pulse and the claimed ID.
REQ-015 SHALL have ports complete_o [NumTarget-1:0] and complete_id_o [NumTarget-1:0][IdW-1:0] (output): one-cycle complete pulse and the completed ID.

Function
REQ-016 The address map SHALL be: priority k at Base+4k; pending word w at Base+0x1000+4w; enable word w of target t at Base+0x2000+0x80t+4w; threshold t at Base+0x20_0000+0x1000t; claim/complete t at Base+0x20_0004+0x1000t.
REQ-017 The bus FSM SHALL have two states: IDLE and RESP; IDLE->RESP when valid=1 (the request is latched); RESP->IDLE unconditionally; ready=1 only in RESP; latency is exactly one cycle; the requester holds valid until ready.
REQ-018 The rdata and error outputs SHALL be registered and SHALL be 0 whenever ready=0.
REQ-019 State updates and pulses SHALL occur exactly once per transaction, on the IDLE->RESP edge; a valid held through RESP SHALL NOT be treated as a second access.
REQ-020 A priority write SHALL take effect when wstrb[0]=1; values above MaxPrio SHALL saturate to MaxPrio; writes to prio[0] SHALL be ignored with error=0.
REQ-021 Enable writes SHALL honour wstrb per byte; bit 0 of word 0 and bits above NumSource SHALL stay 0.
REQ-022 A threshold write SHALL take effect when wstrb[0]=1, saturating at MaxPrio.
REQ-023 Reads SHALL return the stored value zero-extended; prio[0], ip bit 0 and bits above NumSource SHALL read 0; pending words SHALL be read-only, and writes to them SHALL return error=1.
REQ-024 A claim read of target t SHALL return cc_i[t] as sampled on acceptance, and SHALL pulse claim_o[t] with claim_id_o[t] set to that value, even when the value is 0.
REQ-025 A complete write to target t with 1 <= wdata <= NumSource SHALL pulse complete_o[t] with complete_id_o[t]=wdata[IdW-1:0]; any other value SHALL be ignored with error=0.
REQ-026 An unmapped address SHALL produce error=1 and rdata=0, with no state change and no pulse.
REQ-027 Pulse outputs SHALL be registered and SHALL coincide with ready=1.

Reset
REQ-028 While rst_ni=0 at a clock edge, the block SHALL reset FSM=IDLE, all prio/ie/threshold storage=0, all pulses=0, and ready/rdata/error=0.
REQ-029 A reset asserted during RESP SHALL abort the transaction: no pulse is issued and the next cycle has ready=0.

Verification
REQ-030 Write 0x9 to Base+0x8 (prio 2), then read it -> prio_o[2]=7 (saturated), rdata=7, each ready exactly one cycle after valid.
REQ-031 Write 0xFFFF_FFFF to Base+0x2084 with wstrb=4'b0011 (target 1, word 1) -> ie_o[1][47:32]=16'hFFFF, ie_o[1][63:48]=0; a read-back returns 0x0000_FFFF.
REQ-032 With cc_i[0]=5, read Base+0x20_0004 with valid held 3 cycles -> rdata=5 and exactly one claim_o[0] pulse with claim_id_o[0]=5.
REQ-033 Write 5, then 0, then 64 to Base+0x20_1004 -> exactly one complete_o[1] pulse with complete_id_o[1]=5; all three writes return error=0.
REQ-034 Write to Base+0x1000 and read Base+0x0400_0000 -> error=1, no state change; with ip_i[33]=1, a read of Base+0x1004 returns 0x2.
REQ-035 Assert rst_ni=0 in the RESP cycle of a claim read -> no claim pulse is issued, and all outputs read 0 on the following cycle.
